// File: rtl/imem_fetch_if.sv
// Load/fetch bus of the instruction-memory fetch unit.
// The master drives the program-load and fetch requests. The slave returns the fetched instruction and its status.
interface imem_fetch_if #(
  parameter int CNT_W = 16
);
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [31:0]      ld_data;
  logic             ld_done;
  logic             fetch_req;
  logic [31:0]      fetch_pc;
  logic             fetch_stall;
  logic             fetch_ready;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [31:0]      instr_pc;
  logic [1:0]       fault;
  logic [CNT_W-1:0] ld_count;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_done,
    output fetch_req, fetch_pc, fetch_stall,
    input  fetch_ready, instr, instr_valid, instr_pc, fault, ld_count
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_done,
    input  fetch_req, fetch_pc, fetch_stall,
    output fetch_ready, instr, instr_valid, instr_pc, fault, ld_count
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a program-load phase followed by 1-cycle-latency fetches.
// Out-of-range and misaligned fetches are flagged and return NOP_WORD.
module imem_fetch_unit #(
  parameter int          IM_BYTES = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  imem_fetch_if.slave   bus
);
  localparam int          WORDS = IM_BYTES / 4;
  localparam int          AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] LAST  = 32'(IM_BYTES - 4);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] ld_count;
  logic [31:0]      instr_q;
  logic             instr_valid_q;
  logic [31:0]      instr_pc_q;
  logic [1:0]       fault_q;

  // Each entry holds one big-endian word: byte A is bits [31:24] of the word at A & ~3.
  logic [31:0] mem [WORDS];

  logic [31:0]   ld_waddr;
  logic          ld_in_range;
  logic          wr_en;
  logic [1:0]    fetch_fault;
  logic [31:0]   fetch_word;
  logic          fetch_go;
  logic [AW-1:0] ld_idx;
  logic [AW-1:0] fetch_idx;
  logic          unused_bits;

  assign ld_waddr    = {bus.ld_addr[31:2], 2'b00};
  assign ld_in_range = (ld_waddr <= LAST);
  assign ld_idx      = bus.ld_addr[AW+1:2];
  assign fetch_idx   = bus.fetch_pc[AW+1:2];
  assign unused_bits = ^bus.ld_addr[1:0];

  // A write while reset is held must not land; the array itself has no reset.
  assign wr_en = reset_n && (state == S_LOAD) && bus.ld_valid && ld_in_range;

  assign fetch_fault = {(bus.fetch_pc > LAST), (bus.fetch_pc[1:0] != 2'b00)};
  assign fetch_go    = (state == S_RUN) && bus.fetch_req && !bus.fetch_stall;

  always_comb begin
    fetch_word = NOP_WORD;
    if (fetch_fault == 2'b00) fetch_word = mem[fetch_idx];
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[ld_idx] <= bus.ld_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_LOAD;
      ld_count      <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      fault_q       <= 2'b00;
    end else begin
      if (state == S_LOAD) begin
        if (bus.ld_valid && ld_in_range && (ld_count != {CNT_W{1'b1}}))
          ld_count <= ld_count + 1'b1;
        if (bus.ld_done) state <= S_RUN;
      end
      // With the stall raised, the whole output set freezes.
      if (!bus.fetch_stall) begin
        if (fetch_go) begin
          instr_q       <= fetch_word;
          instr_valid_q <= 1'b1;
          instr_pc_q    <= bus.fetch_pc;
          fault_q       <= fetch_fault;
        end else begin
          instr_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.fetch_ready = (state == S_RUN);
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fault       = fault_q;
  assign bus.ld_count    = ld_count;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: a vector table covering load and fetch, plus a hand-written reset sequence.
module tb_imem_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  imem_fetch_if #(.CNT_W(16)) bus ();

  imem_fetch_unit #(.IM_BYTES(1024), .NOP_WORD(NOP), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        dn;
    logic        rq;
    logic [31:0] pc;
    logic        st;
    logic        e_rdy;
    logic        e_iv;
    logic [31:0] e_ins;
    logic [31:0] e_ipc;
    logic [1:0]  e_f;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic iv, input logic [31:0] ins,
                         input logic [31:0] ipc, input logic [1:0] f, input logic [15:0] cnt);
    chk({tag, ".ready"}, {31'd0, bus.fetch_ready}, {31'd0, rdy});
    chk({tag, ".ivalid"}, {31'd0, bus.instr_valid}, {31'd0, iv});
    chk({tag, ".instr"}, bus.instr, ins);
    chk({tag, ".ipc"}, bus.instr_pc, ipc);
    chk({tag, ".fault"}, {30'd0, bus.fault}, {30'd0, f});
    chk({tag, ".count"}, {16'd0, bus.ld_count}, {16'd0, cnt});
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic dn,
                       input logic rq, input logic [31:0] pc, input logic st);
    bus.ld_valid    = v;
    bus.ld_addr     = a;
    bus.ld_data     = d;
    bus.ld_done     = dn;
    bus.fetch_req   = rq;
    bus.fetch_pc    = pc;
    bus.fetch_stall = st;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    //        v  addr           data           dn rq pc             st | rdy iv instr          ipc            f      cnt
    vecs[0]  = '{1, 32'h0000_0000, 32'h2008_0005, 0, 1, 32'h0000_0000, 0, 0, 0, 32'h0,         32'h0,         2'b00, 16'd1};
    vecs[1]  = '{1, 32'h0000_0004, 32'h2009_000A, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         2'b00, 16'd2};
    vecs[2]  = '{1, 32'h0000_0400, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         2'b00, 16'd2};
    vecs[3]  = '{1, 32'h0000_03FF, 32'hCAFE_F00D, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         2'b00, 16'd3};
    vecs[4]  = '{1, 32'h0000_0008, 32'h1122_3344, 1, 1, 32'h0000_0000, 0, 1, 0, 32'h0,         32'h0,         2'b00, 16'd4};
    vecs[5]  = '{1, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0000_0004, 0, 1, 1, 32'h2009_000A, 32'h4,         2'b00, 16'd4};
    vecs[6]  = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0000, 0, 1, 1, 32'h2008_0005, 32'h0,         2'b00, 16'd4};
    vecs[7]  = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0006, 0, 1, 1, NOP,           32'h6,         2'b01, 16'd4};
    vecs[8]  = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_03FE, 0, 1, 1, NOP,           32'h3FE,       2'b11, 16'd4};
    vecs[9]  = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0400, 0, 1, 1, NOP,           32'h400,       2'b10, 16'd4};
    vecs[10] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_03FC, 0, 1, 1, 32'hCAFE_F00D, 32'h3FC,       2'b00, 16'd4};
    vecs[11] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0008, 0, 1, 1, 32'h1122_3344, 32'h8,         2'b00, 16'd4};
    vecs[12] = '{0, 32'h0,         32'h0,         0, 0, 32'h0000_0010, 0, 1, 0, 32'h1122_3344, 32'h8,         2'b00, 16'd4};
    vecs[13] = '{0, 32'h0,         32'h0,         0, 1, 32'hFFFF_FFFC, 0, 1, 1, NOP,           32'hFFFF_FFFC, 2'b10, 16'd4};
    vecs[14] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0000, 0, 1, 1, 32'h2008_0005, 32'h0,         2'b00, 16'd4};
    vecs[15] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0004, 1, 1, 1, 32'h2008_0005, 32'h0,         2'b00, 16'd4};
    vecs[16] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0008, 1, 1, 1, 32'h2008_0005, 32'h0,         2'b00, 16'd4};
    vecs[17] = '{0, 32'h0,         32'h0,         0, 0, 32'h0000_03FE, 1, 1, 1, 32'h2008_0005, 32'h0,         2'b00, 16'd4};
    vecs[18] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0004, 0, 1, 1, 32'h2009_000A, 32'h4,         2'b00, 16'd4};
    vecs[19] = '{0, 32'h0,         32'h0,         0, 0, 32'h0000_0008, 1, 1, 1, 32'h2009_000A, 32'h4,         2'b00, 16'd4};

    reset_n = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    #3;
    chk_all("reset", 0, 0, 32'h0, 32'h0, 2'b00, 16'd0);
    #9;
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].dn, vecs[i].rq, vecs[i].pc, vecs[i].st);
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_iv, vecs[i].e_ins,
              vecs[i].e_ipc, vecs[i].e_f, vecs[i].e_cnt);
    end

    // Reset asserted between edges must clear outputs without a clock edge.
    drive(0, 32'h0, 32'h0, 0, 1, 32'h0000_0004, 0);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 32'h0, 32'h0, 2'b00, 16'd0);
    // A load write presented while reset is held must be dropped.
    drive(1, 32'h0000_0000, 32'hBAD0_BAD0, 1, 1, 32'h0, 0);
    step();
    chk_all("rst_hold", 0, 0, 32'h0, 32'h0, 2'b00, 16'd0);
    #2;
    reset_n = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 1, 32'h0000_0000, 0);
    step();
    chk_all("no_done0", 0, 0, 32'h0, 32'h0, 2'b00, 16'd0);
    step();
    chk_all("no_done1", 0, 0, 32'h0, 32'h0, 2'b00, 16'd0);
    drive(0, 32'h0, 32'h0, 1, 1, 32'h0000_0000, 0);
    step();
    chk_all("redone", 1, 0, 32'h0, 32'h0, 2'b00, 16'd0);
    drive(0, 32'h0, 32'h0, 0, 1, 32'h0000_0000, 0);
    step();
    chk_all("keep0", 1, 1, 32'h2008_0005, 32'h0, 2'b00, 16'd0);
    drive(0, 32'h0, 32'h0, 0, 1, 32'h0000_03FC, 0);
    step();
    chk_all("keep3fc", 1, 1, 32'hCAFE_F00D, 32'h3FC, 2'b00, 16'd0);
    drive(0, 32'h0, 32'h0, 0, 1, 32'h0000_0008, 0);
    step();
    chk_all("keep8", 1, 1, 32'h1122_3344, 32'h8, 2'b00, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
